// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle LEGv8-subset controller:
// FSM states, instruction classes, opcode patterns, ALU / pc_src / fault codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_NONE,
        CL_ADD,
        CL_SUB,
        CL_AND,
        CL_ORR,
        CL_LDUR,
        CL_STUR,
        CL_CBZ,
        CL_B
    } iclass_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // CBZ and B are matched on their leading bits only
    localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;
    localparam logic [5:0]  OP_B_HI   = 6'b000101;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_CB  = 2'b01;
    localparam logic [1:0] PC_B   = 2'b10;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_ILLEGAL  = 2'b01;
    localparam logic [1:0] FC_FETCH_TO = 2'b10;
    localparam logic [1:0] FC_DATA_TO  = 2'b11;

endpackage

// File: rtl/cpu_insn_decode.sv
// Combinational opcode classifier: opcode -> instruction class, ALU control, illegal flag.
module cpu_insn_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [10:0] opcode_i,
    output iclass_e     iclass_o,
    output logic [3:0]  alu_ctrl_o,
    output logic        illegal_o
);

    always_comb begin
        iclass_o   = CL_NONE;
        alu_ctrl_o = ALU_ADD;
        illegal_o  = 1'b0;
        if (opcode_i == OP_ADD) begin
            iclass_o = CL_ADD;
        end else if (opcode_i == OP_SUB) begin
            iclass_o   = CL_SUB;
            alu_ctrl_o = ALU_SUB;
        end else if (opcode_i == OP_AND) begin
            iclass_o   = CL_AND;
            alu_ctrl_o = ALU_AND;
        end else if (opcode_i == OP_ORR) begin
            iclass_o   = CL_ORR;
            alu_ctrl_o = ALU_ORR;
        end else if (opcode_i == OP_LDUR) begin
            iclass_o = CL_LDUR;
        end else if (opcode_i == OP_STUR) begin
            iclass_o = CL_STUR;
        end else if (opcode_i[10:3] == OP_CBZ_HI) begin
            iclass_o   = CL_CBZ;
            alu_ctrl_o = ALU_PASSB;
        end else if (opcode_i[10:5] == OP_B_HI) begin
            iclass_o = CL_B;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle control FSM for the LEGv8-subset datapath with RAM req/ack timeout.
// Optional performance counters (cycle_cnt, instr_cnt) are built when CTRL_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | instruction RAM request until ack
// DECODE | latch class; B completes here
// EXEC   | ALU operation; CBZ completes here
// MEM    | data RAM request until ack; STUR completes here
// WB     | register write-back
// HALT   | fault, only reset leaves
module cpu_multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [10:0]      opcode,
    input  logic             zero_flag,
    input  logic             mem_ack,
    output logic             ins_read,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg2loc,
    output logic             alu_src,
    output logic [3:0]       alu_ctrl,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             retire,
    output logic             busy,
    output logic             fault,
`ifdef CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
`endif
    output logic [1:0]       fault_code
);

    localparam int TO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    iclass_e         iclass_q, iclass_d;
    logic [3:0]      alu_q, alu_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]      fcode_q, fcode_d;

    iclass_e    dec_class;
    logic [3:0] dec_alu;
    logic       dec_illegal;
    logic       to_hit;

    cpu_insn_decode u_decode (
        .opcode_i   (opcode),
        .iclass_o   (dec_class),
        .alu_ctrl_o (dec_alu),
        .illegal_o  (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            iclass_q <= CL_NONE;
            alu_q    <= '0;
            to_cnt_q <= '0;
            fcode_q  <= FC_NONE;
        end else begin
            state_q  <= state_d;
            iclass_q <= iclass_d;
            alu_q    <= alu_d;
            to_cnt_q <= to_cnt_d;
            fcode_q  <= fcode_d;
        end
    end

    // The timeout cycle drops the RAM request but still honours a late ack.
    assign to_hit = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        iclass_d   = iclass_q;
        alu_d      = alu_q;
        to_cnt_d   = to_cnt_q;
        fcode_d    = fcode_q;
        ins_read   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = 4'b0000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    to_cnt_d = '0;
                end
            end
            ST_FETCH: begin
                ins_read = !to_hit;
                ir_write = mem_ack;
                if (mem_ack) begin
                    state_d = ST_DECODE;
                end else if (to_hit) begin
                    state_d = ST_HALT;
                    fcode_d = FC_FETCH_TO;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_DECODE: begin
                iclass_d = dec_class;
                alu_d    = dec_alu;
                if (dec_illegal) begin
                    state_d = ST_HALT;
                    fcode_d = FC_ILLEGAL;
                end else if (dec_class == CL_B) begin
                    pc_write = 1'b1;
                    pc_src   = PC_B;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                    to_cnt_d = '0;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_ctrl = alu_q;
                case (iclass_q)
                    CL_LDUR, CL_STUR: begin
                        alu_src  = 1'b1;
                        reg2loc  = (iclass_q == CL_STUR);
                        state_d  = ST_MEM;
                        to_cnt_d = '0;
                    end
                    CL_CBZ: begin
                        reg2loc  = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = zero_flag ? PC_CB : PC_SEQ;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                        to_cnt_d = '0;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                alu_ctrl = alu_q;
                alu_src  = 1'b1;
                reg2loc  = (iclass_q == CL_STUR);
                if (iclass_q == CL_STUR) mem_write = !to_hit;
                else                     mem_read  = !to_hit;
                if (mem_ack) begin
                    if (iclass_q == CL_STUR) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                        to_cnt_d = '0;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (to_hit) begin
                    state_d = ST_HALT;
                    fcode_d = FC_DATA_TO;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_WB: begin
                alu_ctrl   = alu_q;
                alu_src    = (iclass_q == CL_LDUR);
                mem_to_reg = (iclass_q == CL_LDUR);
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
                to_cnt_d   = '0;
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign fault      = (state_q == ST_HALT);
    assign fault_code = fcode_q;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    // Both counters stop naturally in HALT: busy and retire are low there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (busy)   cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (retire) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    // Counter width only matters when the counters are built.
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Bench for cpu_multicycle_ctrl: per-instruction expected output traces built from the
// instruction rules, compared every cycle, plus literal latency / count checks.
module tb_cpu_multicycle_ctrl;

    localparam int TO = 4;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [10:0] T_CBZ  = 11'b10110100101;
    localparam logic [10:0] T_B    = 11'b00010110011;
    localparam logic [10:0] T_ILL  = 11'b11111111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, zero_flag, mem_ack;
    logic [10:0] opcode;
    logic        ins_read, ir_write, pc_write, reg2loc, alu_src;
    logic [1:0]  pc_src, fault_code;
    logic [3:0]  alu_ctrl;
    logic        mem_read, mem_write, mem_to_reg, reg_write, retire, busy, fault;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    cpu_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .zero_flag  (zero_flag),
        .mem_ack    (mem_ack),
        .ins_read   (ins_read),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg2loc    (reg2loc),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .retire     (retire),
        .busy       (busy),
        .fault      (fault),
`ifdef CTRL_PERF_CNT_EN
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt),
`endif
        .fault_code (fault_code)
    );

    typedef struct packed {
        logic       ins_read;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg2loc;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       retire;
        logic       busy;
        logic       fault;
        logic [1:0] fault_code;
    } vec_t;

    typedef enum int {K_ADD, K_SUB, K_AND, K_ORR, K_LD, K_ST, K_CBZ, K_B, K_ILL} kind_t;

    vec_t  exp_q[$];
    int    id_q[$];
    string lit_name[$];
    int    lit_act[$];
    int    lit_exp[$];

    int checks = 0, failures = 0;
    int cyc_n = 0, vec_id = 0;
    int ret_cyc[$];
    int start_seen = -1;
    int memrd_cnt = 0;
    logic [10:0] cur_op;

    // Single compare process: per-cycle trace vectors and queued literal checks.
    always @(negedge clk) begin
        vec_t act, e;
        int   id;
        cyc_n++;
        act.ins_read   = ins_read;
        act.ir_write   = ir_write;
        act.pc_write   = pc_write;
        act.pc_src     = pc_src;
        act.reg2loc    = reg2loc;
        act.alu_src    = alu_src;
        act.alu_ctrl   = alu_ctrl;
        act.mem_read   = mem_read;
        act.mem_write  = mem_write;
        act.mem_to_reg = mem_to_reg;
        act.reg_write  = reg_write;
        act.retire     = retire;
        act.busy       = busy;
        act.fault      = fault;
        act.fault_code = fault_code;
        if (retire === 1'b1) ret_cyc.push_back(cyc_n);
        if (mem_read === 1'b1) memrd_cnt++;
        if (start && !reset && busy === 1'b0 && fault === 1'b0) start_seen = cyc_n;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL trace#%0d: got %b required %b", id, act, e);
            end
        end
        while (lit_name.size() > 0) begin
            string nm;
            int a, x;
            nm = lit_name.pop_front();
            a  = lit_act.pop_front();
            x  = lit_exp.pop_front();
            checks++;
            if (a != x) begin
                failures++;
                $display("FAIL %s: got %0d required %0d", nm, a, x);
            end
        end
    end

    task automatic lit(input string nm, input int a, input int x);
        lit_name.push_back(nm);
        lit_act.push_back(a);
        lit_exp.push_back(x);
    endtask

    function automatic kind_t kind_of(input logic [10:0] op);
        if (op == T_ADD)  return K_ADD;
        if (op == T_SUB)  return K_SUB;
        if (op == T_AND)  return K_AND;
        if (op == T_ORR)  return K_ORR;
        if (op == T_LDUR) return K_LD;
        if (op == T_STUR) return K_ST;
        if (op[10:3] == 8'b10110100) return K_CBZ;
        if (op[10:5] == 6'b000101)   return K_B;
        return K_ILL;
    endfunction

    function automatic logic [3:0] alu_of(input kind_t k);
        case (k)
            K_SUB:   return 4'b0110;
            K_AND:   return 4'b0000;
            K_ORR:   return 4'b0001;
            K_CBZ:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic vec_t busy_vec();
        vec_t v;
        v = '0;
        v.busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t halt_vec(input logic [1:0] code);
        vec_t v;
        v = '0;
        v.fault = 1'b1;
        v.fault_code = code;
        return v;
    endfunction

    task automatic cyc(input logic rst_v, input logic st_v, input logic ack_v,
                       input logic zf_v, input vec_t e);
        @(posedge clk);
        #1;
        reset     = rst_v;
        start     = st_v;
        mem_ack   = ack_v;
        zero_flag = zf_v;
        opcode    = cur_op;
        exp_q.push_back(e);
        id_q.push_back(vec_id);
        vec_id++;
    endtask

    // fw/mw: cycles without ack before ack in FETCH/MEM (>= TO means never).
    // tie: mem_ack level in cycles that do not wait on RAM.
    task automatic run_insn(input logic [10:0] op, input int fw, input int mw,
                            input logic zf, input logic tie);
        kind_t k;
        vec_t  v;
        k = kind_of(op);
        cur_op = op;
        for (int i = 0; i < TO; i++) begin
            v = busy_vec();
            v.ins_read = (i != TO - 1);
            v.ir_write = (i == fw);
            cyc(1'b0, 1'b0, (i == fw), 1'b0, v);
            if (i == fw) break;
            if (i == TO - 1) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0, halt_vec(2'b10));
                return;
            end
        end
        v = busy_vec();
        if (k == K_B) begin
            v.pc_write = 1'b1;
            v.pc_src   = 2'b10;
            v.retire   = 1'b1;
        end
        cyc(1'b0, 1'b0, tie, 1'b0, v);
        if (k == K_ILL) begin
            cyc(1'b0, 1'b0, tie, 1'b0, halt_vec(2'b01));
            return;
        end
        if (k == K_B) return;
        v = busy_vec();
        v.alu_ctrl = alu_of(k);
        if (k == K_LD || k == K_ST) begin
            v.alu_src = 1'b1;
            v.reg2loc = (k == K_ST);
        end
        if (k == K_CBZ) begin
            v.reg2loc  = 1'b1;
            v.pc_write = 1'b1;
            v.pc_src   = zf ? 2'b01 : 2'b00;
            v.retire   = 1'b1;
        end
        cyc(1'b0, 1'b0, tie, zf, v);
        if (k == K_CBZ) return;
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < TO; i++) begin
                v = busy_vec();
                v.alu_ctrl  = 4'b0010;
                v.alu_src   = 1'b1;
                v.reg2loc   = (k == K_ST);
                v.mem_read  = (k == K_LD) && (i != TO - 1);
                v.mem_write = (k == K_ST) && (i != TO - 1);
                if (k == K_ST && i == mw) begin
                    v.pc_write = 1'b1;
                    v.retire   = 1'b1;
                end
                cyc(1'b0, 1'b0, (i == mw), 1'b0, v);
                if (i == mw) break;
                if (i == TO - 1) begin
                    cyc(1'b0, 1'b0, 1'b0, 1'b0, halt_vec(2'b11));
                    return;
                end
            end
            if (k == K_ST) return;
        end
        v = busy_vec();
        v.reg_write  = 1'b1;
        v.mem_to_reg = (k == K_LD);
        v.alu_ctrl   = alu_of(k);
        v.alu_src    = (k == K_LD);
        v.pc_write   = 1'b1;
        v.retire     = 1'b1;
        cyc(1'b0, 1'b0, tie, 1'b0, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat [10];
        vec_t v;
        lat = '{4, 4, 4, 4, 7, 5, 3, 3, 2, 8};
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0; zero_flag = 1'b0;
        opcode = '0; cur_op = '0;

        // Phase A: program of every class, ending in a data timeout
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_insn(T_ADD, 0, 0, 1'b0, 1'b1);
        run_insn(T_SUB, 0, 0, 1'b0, 1'b1);
        run_insn(T_AND, 0, 0, 1'b0, 1'b1);
        run_insn(T_ORR, 0, 0, 1'b0, 1'b1);
        memrd_cnt = 0;
        run_insn(T_LDUR, 0, 2, 1'b0, 1'b0);
        lit("ldur mem_read cycles", memrd_cnt, 3);
        run_insn(T_STUR, 1, 0, 1'b0, 1'b0);
        run_insn(T_CBZ, 0, 0, 1'b1, 1'b0);
        run_insn(T_CBZ, 0, 0, 1'b0, 1'b0);
        run_insn(T_B, 0, 0, 1'b0, 1'b0);
        run_insn(T_LDUR, 3, 0, 1'b0, 1'b0);
        run_insn(T_STUR, 0, TO, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, halt_vec(2'b11));
        lit("retire count A", ret_cyc.size(), 10);
        if (ret_cyc.size() >= 10) begin
            for (int i = 0; i < 10; i++)
                lit($sformatf("latency insn %0d", i),
                    (i == 0) ? ret_cyc[0] - start_seen : ret_cyc[i] - ret_cyc[i-1], lat[i]);
        end

        // Phase B: illegal opcode
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_insn(T_ILL, 0, 0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, halt_vec(2'b01));

        // Phase C: fetch timeout
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_insn(T_ADD, TO, 0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, halt_vec(2'b10));

        // Phase D: asynchronous reset during LDUR MEM, then clean restart
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        cur_op = T_LDUR;
        v = busy_vec(); v.ins_read = 1'b1; v.ir_write = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, v);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, busy_vec());
        v = busy_vec(); v.alu_ctrl = 4'b0010; v.alu_src = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, v);
        v.mem_read = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, v);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        #1;
        lit("mem_read before abort", int'(mem_read), 1);
        reset = 1'b1;
        #1;
        lit("mem_read after abort", int'(mem_read), 0);
        lit("busy after abort", int'(busy), 0);
        lit("alu_src after abort", int'(alu_src), 0);
        lit("fault after abort", int'(fault), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_insn(T_ADD, 0, 0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        lit("retire count total", ret_cyc.size(), 11);
        if (ret_cyc.size() >= 11)
            lit("latency after abort", ret_cyc[10] - start_seen, 4);

        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
